regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//   Shares the single write port of the 32 x 32-bit register file between NREQ writeback
//   requesters, for example the ALU writeback and the load writeback.
//   - Arbitration is round-robin; at most one request is accepted per cycle.
//   - The accepted request is registered and presented to the register file one cycle later.
//   - Writes to the hardwired zero register are accepted but suppressed.
//   - Sits between the pipeline writeback stage and the regfile write/address/data inputs.
// PARAMETERS
//   NREQ      2   number of requesters (>=2)
//   ADDR_W    5   register address width
//   DATA_W    32  register data width
//   ZERO_REG  31  address whose writes are dropped (XZR)
// PORTS
//   clk            in   1             clock, all state on rising edge
//   reset          in   1             asynchronous, active-high reset
//   req_valid      in   NREQ          requester i has a write pending
//   req_addr       in   NREQ*ADDR_W   dest register, slice i = [i*ADDR_W +: ADDR_W]
//   req_data       in   NREQ*DATA_W   write data, slice i = [i*DATA_W +: DATA_W]
//   req_ready      out  NREQ          one-hot (or zero) grant; accept = valid & ready
//   rf_stall       in   1             freeze: regfile write port unavailable this cycle
//   rf_write_en    out  1             write strobe to regfile
//   rf_write_addr  out  ADDR_W        regfile write address
//   rf_write_data  out  DATA_W        regfile write data
//   rr_ptr_o       out  $clog2(NREQ)  current highest-priority requester (debug)
// BEHAVIOUR
//   State
//   - out_valid / out_addr / out_data: output stage.
//   - rr_ptr: round-robin priority pointer.
//   Reset (async, immediate)
//   - out_valid=0, out_addr=0, out_data=0, rr_ptr=0.
//   - rf_write_en=0 and req_ready=0 while reset is high.
//   Arbitration (combinational)
//   - can_accept = !rf_stall.
//   - Scan requesters rr_ptr, rr_ptr+1, ... (mod NREQ); the first with req_valid=1 is winner w.
//   - req_ready[w]=1 only if can_accept; all other req_ready bits are 0.
//   - No valid requester, or rf_stall=1 -> req_ready=0.
//   - req_ready never depends on req_data or req_addr.
//   Accept edge (winner exists and can_accept)
//   - out_valid<=1, out_addr<=req_addr[w], out_data<=req_data[w].
//   - rr_ptr<=(w+1) mod NREQ; wrap from NREQ-1 to 0.
//   Other edges
//   - No accept and rf_stall=0 -> out_valid<=0; out_addr/out_data hold (don't care).
//   - rf_stall=1 -> out_valid, out_addr, out_data and rr_ptr all hold.
//   Outputs and latency
//   - rf_write_en = out_valid & !rf_stall & (out_addr != ZERO_REG).
//   - rf_write_addr = out_addr; rf_write_data = out_data (registered outputs).
//   - Latency: accept at edge N -> regfile write strobe during cycle N+1 (1 cycle).
//   - Throughput: 1 write/cycle when unstalled.
//   Ordering and fairness
//   - Writes issue in acceptance order. If two requesters target the same register in one
//     cycle, the loser's write lands one cycle later and is the final value.
//   - No starvation: a continuously valid requester is granted within NREQ accept cycles.
//   Boundary cases
//   - ZERO_REG write: handshake completes and rr_ptr advances; rf_write_en stays 0.
//   - Stall while out_valid=1: entry held, no new grant; it is written in the first
//     unstalled cycle.
//   - Reset mid-transfer: the held entry is discarded, never written; no partial state.
//   - Requester dropping req_valid without a grant is legal; nothing is recorded.
// TESTING
//   1. req_valid=01, addr0=3, data0=0xDEADBEEF -> req_ready=01 same cycle; next cycle
//      rf_write_en=1, addr=3, data=0xDEADBEEF; following cycle rf_write_en=0.
//   2. Both valid for 6 cycles (addr0=1, addr1=2) -> grants 01,10,01,10,01,10;
//      rf_write_addr 1,2,1,2,1,2, one cycle delayed.
//   3. req0 writes addr 31 with data 0x5 -> req_ready[0]=1, rr_ptr becomes 1,
//      rf_write_en stays 0.
//   4. Accept addr 7; raise rf_stall for 3 cycles -> req_ready=0 and rf_write_en=0 for 3 cycles,
//      rf_write_addr holds 7; stall drops -> write of addr 7 issues.
//   5. Assert reset mid-cycle with out_valid=1 -> rf_write_en, out_valid and req_ready go to 0
//      before the next clk edge; after release req0 wins first (rr_ptr=0).
//   6. NREQ=3, valid pattern 101 held -> grants 001,100,001,100; requester 1 is skipped
//      without stalling the rotation.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between NREQ writeback
// requesters; accepted writes are registered and presented one cycle later.
module regfile_write_arbiter #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     rf_stall,
    output logic                     rf_write_en,
    output logic [ADDR_W-1:0]        rf_write_addr,
    output logic [DATA_W-1:0]        rf_write_data,
    output logic [$clog2(NREQ)-1:0]  rr_ptr_o
);

    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam int unsigned CW    = PTR_W + 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  winner;
    logic [PTR_W-1:0]  ptr_next;
    logic [CW-1:0]     cand;
    logic              found;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    // Scan from rr_ptr upward (mod NREQ); first valid requester wins.
    always_comb begin : scan
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!found && req_valid[cand[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[PTR_W-1:0];
            end
        end
    end

    // Payload mux driven by the winning index.
    always_comb begin : payload_mux
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == PTR_W'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_next = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + PTR_W'(1);

    // Grant depends only on valids, pointer and stall; forced low during reset.
    always_comb begin : grant
        req_ready = '0;
        if (found && !rf_stall && !reset) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Output stage and pointer freeze entirely while the regfile port is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            rr_ptr    <= '0;
        end else if (!rf_stall) begin
            out_valid <= found;
            if (found) begin
                out_addr <= sel_addr;
                out_data <= sel_data;
                rr_ptr   <= ptr_next;
            end
        end
    end

    assign rf_write_en   = out_valid & ~rf_stall & (out_addr != ADDR_W'(ZERO_REG));
    assign rf_write_addr = out_addr;
    assign rf_write_data = out_data;
    assign rr_ptr_o      = rr_ptr;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of regfile_write_arbiter (NREQ=2 and NREQ=3 instances)
// against a transaction-level reference model.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic [1:0]  a_valid;
    logic [9:0]  a_addr;
    logic [63:0] a_data;
    logic [1:0]  a_ready;
    logic        a_stall;
    logic        a_we;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic [0:0]  a_ptr;

    logic [2:0]  b_valid;
    logic [14:0] b_addr;
    logic [95:0] b_data;
    logic [2:0]  b_ready;
    logic        b_stall;
    logic        b_we;
    logic [4:0]  b_wa;
    logic [31:0] b_wd;
    logic [1:0]  b_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: priority pointer and pending output entry per instance.
    int          ma_ptr, mb_ptr;
    logic        ma_ov, mb_ov;
    logic [4:0]  ma_oa, mb_oa;
    logic [31:0] ma_od, mb_od;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.NREQ(2)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_addr(a_addr), .req_data(a_data), .req_ready(a_ready),
        .rf_stall(a_stall), .rf_write_en(a_we), .rf_write_addr(a_wa), .rf_write_data(a_wd),
        .rr_ptr_o(a_ptr)
    );

    regfile_write_arbiter #(.NREQ(3)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_addr(b_addr), .req_data(b_data), .req_ready(b_ready),
        .rf_stall(b_stall), .rf_write_en(b_we), .rf_write_addr(b_wa), .rf_write_data(b_wd),
        .rr_ptr_o(b_ptr)
    );

    function automatic int winner(input int n, input int ptr, input logic [2:0] v);
        for (int k = 0; k < n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_model();
        ma_ptr = 0; ma_ov = 1'b0; ma_oa = '0; ma_od = '0;
        mb_ptr = 0; mb_ov = 1'b0; mb_oa = '0; mb_od = '0;
    endtask

    // Check both instances against the model, then advance one clock.
    task automatic step();
        int wa_i, wb_i;
        logic [1:0] er_a;
        logic [2:0] er_b;
        #1;
        if (reset) zero_model();
        wa_i = winner(2, ma_ptr, {1'b0, a_valid});
        wb_i = winner(3, mb_ptr, b_valid);
        er_a = (wa_i >= 0 && !a_stall && !reset) ? 2'(1 << wa_i) : 2'b00;
        er_b = (wb_i >= 0 && !b_stall && !reset) ? 3'(1 << wb_i) : 3'b000;
        check("a_ready", 64'(a_ready), 64'(er_a));
        check("a_we", 64'(a_we), 64'(ma_ov && !a_stall && ma_oa != 5'd31));
        check("a_ptr", 64'(a_ptr), 64'(ma_ptr));
        if (ma_ov) begin
            check("a_waddr", 64'(a_wa), 64'(ma_oa));
            check("a_wdata", 64'(a_wd), 64'(ma_od));
        end
        check("b_ready", 64'(b_ready), 64'(er_b));
        check("b_we", 64'(b_we), 64'(mb_ov && !b_stall && mb_oa != 5'd31));
        check("b_ptr", 64'(b_ptr), 64'(mb_ptr));
        if (mb_ov) begin
            check("b_waddr", 64'(b_wa), 64'(mb_oa));
            check("b_wdata", 64'(b_wd), 64'(mb_od));
        end
        @(posedge clk);
        if (reset) begin
            zero_model();
        end else begin
            if (!a_stall) begin
                ma_ov = (wa_i >= 0);
                if (wa_i >= 0) begin
                    ma_oa  = a_addr[wa_i*5 +: 5];
                    ma_od  = a_data[wa_i*32 +: 32];
                    ma_ptr = (wa_i + 1) % 2;
                end
            end
            if (!b_stall) begin
                mb_ov = (wb_i >= 0);
                if (wb_i >= 0) begin
                    mb_oa  = b_addr[wb_i*5 +: 5];
                    mb_od  = b_data[wb_i*32 +: 32];
                    mb_ptr = (wb_i + 1) % 3;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] exp_b [4];
        reset   = 1'b1;
        a_valid = '0; a_addr = '0; a_data = '0; a_stall = 1'b0;
        b_valid = '0; b_addr = '0; b_data = '0; b_stall = 1'b0;
        zero_model();
        @(negedge clk);
        step();
        check("reset_we", 64'(a_we), 64'd0);
        reset = 1'b0;
        step();

        // Single write from requester 0.
        a_valid = 2'b01; a_addr = {5'd0, 5'd3}; a_data = {32'd0, 32'hDEADBEEF};
        #1 check("t1_ready", 64'(a_ready), 64'd1);
        step();
        a_valid = 2'b00;
        #1 check("t1_we", 64'(a_we), 64'd1);
        check("t1_addr", 64'(a_wa), 64'd3);
        check("t1_data", 64'(a_wd), 64'hDEADBEEF);
        step();
        check("t1_we_off", 64'(a_we), 64'd0);

        // Requester 1 alone brings the pointer back to 0.
        a_valid = 2'b10; a_addr = {5'd9, 5'd0}; a_data = {32'h1234, 32'd0};
        step();
        a_valid = 2'b00;
        step();

        // Both requesters valid: strict alternation.
        a_addr = {5'd2, 5'd1}; a_data = {32'hBBBB, 32'hAAAA};
        for (int i = 0; i < 6; i++) begin
            a_valid = 2'b11;
            #1 check("t2_grant", 64'(a_ready), (i % 2 == 1) ? 64'd2 : 64'd1);
            if (i > 0) check("t2_waddr", 64'(a_wa), (i % 2 == 1) ? 64'd1 : 64'd2);
            step();
        end
        a_valid = 2'b00;
        step();

        // Write to zero register: handshake and pointer advance, no strobe.
        a_valid = 2'b01; a_addr = {5'd0, 5'd31}; a_data = {32'd0, 32'h5};
        #1 check("t3_ready", 64'(a_ready), 64'd1);
        step();
        a_valid = 2'b00;
        #1 check("t3_ptr", 64'(a_ptr), 64'd1);
        check("t3_we", 64'(a_we), 64'd0);
        step();

        // Stall holds the accepted entry for three cycles.
        a_valid = 2'b01; a_addr = {5'd0, 5'd7}; a_data = {32'd0, 32'h77};
        step();
        a_valid = 2'b11; a_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("t4_stall_we", 64'(a_we), 64'd0);
            check("t4_stall_addr", 64'(a_wa), 64'd7);
            step();
        end
        a_valid = 2'b00; a_stall = 1'b0;
        #1 check("t4_release_we", 64'(a_we), 64'd1);
        step();

        // Reset mid-cycle discards the pending entry.
        a_valid = 2'b01; a_addr = {5'd0, 5'd12}; a_data = {32'd0, 32'hC0FFEE};
        step();
        a_valid = 2'b11;
        #1 reset = 1'b1;
        #1 check("t5_we", 64'(a_we), 64'd0);
        check("t5_ready", 64'(a_ready), 64'd0);
        zero_model();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 check("t5_first_grant", 64'(a_ready), 64'd1);
        step();
        a_valid = 2'b00;
        step();

        // Three requesters, pattern 101: requester 1 skipped.
        exp_b[0] = 3'b001; exp_b[1] = 3'b100; exp_b[2] = 3'b001; exp_b[3] = 3'b100;
        b_addr = {5'd6, 5'd5, 5'd4}; b_data = {32'h66, 32'h55, 32'h44};
        for (int i = 0; i < 4; i++) begin
            b_valid = 3'b101;
            #1 check("t6_grant", 64'(b_ready), 64'(exp_b[i]));
            step();
        end
        b_valid = 3'b000;
        step();

        // Randomized traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            a_valid = 2'($urandom_range(0, 3));
            b_valid = 3'($urandom_range(0, 7));
            a_stall = ($urandom_range(0, 4) == 0);
            b_stall = ($urandom_range(0, 4) == 0);
            for (int r = 0; r < 3; r++) begin
                if (r < 2) begin
                    a_addr[r*5 +: 5]  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
                    a_data[r*32 +: 32] = $urandom;
                end
                b_addr[r*5 +: 5]  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
                b_data[r*32 +: 32] = $urandom;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
